clk_tick_scheduler: RTL and testbench

Programmable tick controller that owns the system's divided-time base. It sequences a divide counter through idle, continuous and one-shot operation, and accepts run-time divide-ratio updates through a valid/ready handshake. Updates are applied only at a period boundary. Outputs are a one-cycle tick strobe for downstream logic and a toggling clk_out, which is backward compatible with the fixed 50000 divider.

---
 rtl/clk_sched_pkg.sv | 21 ++
 rtl/clk_tick_scheduler_if.sv | 29 ++
 rtl/div_counter.sv | 35 +++
 rtl/clk_tick_scheduler.sv | 145 ++++++++++++++
 tb/tb_clk_tick_scheduler.sv | 226 ++++++++++++++++++++++
 5 files changed

// File: rtl/clk_sched_pkg.sv
// ---------------------------------------------------------------------------
// clk_sched_pkg
// Shared definitions for the tick scheduler slice.
//   sched_state_t : controller states (IDLE, continuous RUN, single-period SHOT)
//   DEFAULT_DIV   : terminal count loaded at reset
//   LEGACY_DIV    : ratio of the original fixed divider; the reset default
//                   equals it, so an unconfigured block behaves like the
//                   old 50000 divider
// ---------------------------------------------------------------------------
package clk_sched_pkg;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_SHOT = 2'd2
    } sched_state_t;

    localparam int unsigned LEGACY_DIV  = 50000;
    localparam int unsigned DEFAULT_DIV = LEGACY_DIV;

endpackage

// File: rtl/clk_tick_scheduler_if.sv
// ---------------------------------------------------------------------------
// clk_tick_scheduler_if
// Valid/ready channel carrying a new divide ratio into the scheduler.
//   cfg_valid : producer offers cfg_div
//   cfg_div   : requested terminal count (0 is treated as 1 by the consumer)
//   cfg_ready : consumer can take a value this cycle
// Modports: master = configuration producer, slave = scheduler.
// ---------------------------------------------------------------------------
interface clk_tick_scheduler_if #(
    parameter int unsigned CNT_W = 32
);

    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;

    modport master (
        output cfg_valid,
        output cfg_div,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_div,
        output cfg_ready
    );

endinterface

// File: rtl/div_counter.sv
// ---------------------------------------------------------------------------
// div_counter
// Free-running divide counter that wraps to zero at a loadable terminal value.
//   clk_in, reset : clock and asynchronous active-low reset
//   clear         : force the count to zero (has priority over enable)
//   enable        : advance the count this cycle
//   term_val      : terminal count; the counter runs 0..term_val
//   count         : current count
//   at_term       : count equals term_val (wrap happens on the next enabled edge)
// ---------------------------------------------------------------------------
module div_counter #(
    parameter int unsigned CNT_W = 32
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    input  logic [CNT_W-1:0] term_val,
    output logic [CNT_W-1:0] count,
    output logic             at_term
);

    assign at_term = (count == term_val);

    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= at_term ? '0 : count + CNT_W'(1);
        end
    end

endmodule

// File: rtl/clk_tick_scheduler.sv
// ---------------------------------------------------------------------------
// clk_tick_scheduler
// Programmable tick controller: IDLE / continuous RUN / one-shot SHOT, with a
// run-time divide ratio taken over a valid/ready channel and applied only at a
// period boundary.
//   clk_in, reset : clock and asynchronous active-low reset
//   start, stop   : level-sampled run control (stop wins over start)
//   oneshot       : sampled with start; run a single period then stop
//   cfg_bus       : divide-ratio channel (slave side)
//   tick          : one-cycle strobe after each terminal count
//   clk_out       : toggles on every tick
//   busy          : high while RUN or SHOT
//   done          : one-cycle pulse, coincident with the final one-shot tick
//   tick_count    : ticks since the last start, wraps
// ---------------------------------------------------------------------------
module clk_tick_scheduler #(
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned DEFAULT_DIV = clk_sched_pkg::DEFAULT_DIV,
    parameter int unsigned TCNT_W      = 16
) (
    input  logic                  clk_in,
    input  logic                  reset,
    input  logic                  start,
    input  logic                  stop,
    input  logic                  oneshot,
    clk_tick_scheduler_if.slave   cfg_bus,
    output logic                  tick,
    output logic                  clk_out,
    output logic                  busy,
    output logic                  done,
    output logic [TCNT_W-1:0]     tick_count
);

    import clk_sched_pkg::*;

    sched_state_t     state_q;
    sched_state_t     state_next;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] div_reg;
    logic [CNT_W-1:0] shadow;
    logic [CNT_W-1:0] cfg_val;
    logic             pending;
    logic             at_term;
    logic             counting;
    logic             terminal;
    logic             starting;
    logic             to_idle;
    logic             cnt_clear;
    logic             cfg_fire;

    assign busy              = (state_q != S_IDLE);
    assign cfg_bus.cfg_ready = !pending;

    div_counter #(
        .CNT_W (CNT_W)
    ) u_div_counter (
        .clk_in   (clk_in),
        .reset    (reset),
        .clear    (cnt_clear),
        .enable   (counting),
        .term_val (div_reg),
        .count    (count),
        .at_term  (at_term)
    );

    // State register
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_next;
        end
    end

    // Next-state and control decode. The counter is cleared in IDLE and on
    // the edge that leaves RUN/SHOT, so a restart always begins at zero.
    always_comb begin
        state_next = state_q;
        counting   = (state_q != S_IDLE);
        terminal   = counting && at_term;
        case (state_q)
            S_IDLE: if (start && !stop) state_next = oneshot ? S_SHOT : S_RUN;
            S_RUN:  if (stop) state_next = S_IDLE;
            S_SHOT: if (stop || terminal) state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
        starting  = (state_q == S_IDLE) && (state_next != S_IDLE);
        to_idle   = counting && (state_next == S_IDLE);
        cnt_clear = (state_q == S_IDLE) || to_idle;
        cfg_fire  = cfg_bus.cfg_valid && !pending;
        cfg_val   = (cfg_bus.cfg_div == '0) ? CNT_W'(1) : cfg_bus.cfg_div;
    end

    // Tick/done strobes, clk_out and the tick counter. A stop on the
    // terminal edge still lets that tick fire.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            tick       <= 1'b0;
            done       <= 1'b0;
            clk_out    <= 1'b0;
            tick_count <= '0;
        end else begin
            tick <= terminal;
            done <= terminal && (state_q == S_SHOT);
            if (terminal) begin
                clk_out <= ~clk_out;
            end
            if (starting) begin
                tick_count <= '0;
            end else if (terminal) begin
                tick_count <= tick_count + TCNT_W'(1);
            end
        end
    end

    // Divide-ratio update. While idle (or on the edge entering idle) a new
    // or pending ratio goes straight into div_reg. While counting it is
    // parked in the shadow register and only swapped in at a terminal
    // count; a value accepted on a terminal edge waits for the next one,
    // which falls out of cfg_ready being low whenever a value is pending.
    always_ff @(posedge clk_in or negedge reset) begin
        if (!reset) begin
            div_reg <= CNT_W'(DEFAULT_DIV);
            shadow  <= '0;
            pending <= 1'b0;
        end else if ((state_q == S_IDLE) || to_idle) begin
            if (cfg_fire) begin
                div_reg <= cfg_val;
            end else if (pending) begin
                div_reg <= shadow;
            end
            pending <= 1'b0;
        end else begin
            if (terminal && pending) begin
                div_reg <= shadow;
                pending <= 1'b0;
            end
            if (cfg_fire) begin
                shadow  <= cfg_val;
                pending <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_clk_tick_scheduler.sv
// ---------------------------------------------------------------------------
// tb_clk_tick_scheduler
// Directed scenarios followed by randomized stimulus, checked every cycle
// against a period-level reference model of the scheduler.
// ---------------------------------------------------------------------------
module tb_clk_tick_scheduler;

    localparam int unsigned CNT_W   = 32;
    localparam int unsigned DEF_DIV = 4;
    localparam int unsigned TCNT_W  = 8;
    localparam int unsigned TMASK   = (1 << TCNT_W) - 1;

    logic              clk_in  = 1'b0;
    logic              reset   = 1'b0;
    logic              start   = 1'b0;
    logic              stop    = 1'b0;
    logic              oneshot = 1'b0;
    logic              tick;
    logic              clk_out;
    logic              busy;
    logic              done;
    logic [TCNT_W-1:0] tick_count;

    int num_checks = 0;
    int num_errors = 0;

    clk_tick_scheduler_if #(.CNT_W(CNT_W)) cfg_bus ();

    clk_tick_scheduler #(
        .CNT_W       (CNT_W),
        .DEFAULT_DIV (DEF_DIV),
        .TCNT_W      (TCNT_W)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .start      (start),
        .stop       (stop),
        .oneshot    (oneshot),
        .cfg_bus    (cfg_bus),
        .tick       (tick),
        .clk_out    (clk_out),
        .busy       (busy),
        .done       (done),
        .tick_count (tick_count)
    );

    always #5 clk_in = ~clk_in;

    // Reference model: mode (0 idle, 1 run, 2 shot), period length in
    // cycles, cycles elapsed in the current period, and a queue holding at
    // most one accepted-but-not-yet-applied ratio.
    int                m_mode;
    longint unsigned   m_period;
    longint unsigned   m_elapsed;
    longint unsigned   m_q[$];
    bit                m_tick;
    bit                m_done;
    bit                m_clk;
    int unsigned       m_tcount;

    task automatic modelReset();
        m_mode    = 0;
        m_period  = DEF_DIV + 1;
        m_elapsed = 0;
        m_q.delete();
        m_tick    = 0;
        m_done    = 0;
        m_clk     = 0;
        m_tcount  = 0;
    endtask

    // One rising edge of the model, using the inputs currently driven.
    task automatic modelEdge();
        bit              ready_now;
        bit              fire;
        bit              wrap;
        bit              leaving;
        longint unsigned val;
        ready_now = (m_q.size() == 0);
        fire      = cfg_bus.cfg_valid && ready_now;
        val       = (cfg_bus.cfg_div == 0) ? 1 : longint'(cfg_bus.cfg_div);
        wrap      = (m_mode != 0) && (m_elapsed + 1 == m_period);
        m_tick    = wrap;
        m_done    = wrap && (m_mode == 2);
        if (wrap) begin
            m_clk    = !m_clk;
            m_tcount = (m_tcount + 1) & TMASK;
        end
        leaving = (m_mode != 0) && (stop || (m_mode == 2 && wrap));
        if (m_mode == 0) begin
            if (fire) m_period = val + 1;
            if (start && !stop) begin
                m_mode    = oneshot ? 2 : 1;
                m_elapsed = 0;
                m_tcount  = 0;
            end
        end else if (leaving) begin
            m_mode    = 0;
            m_elapsed = 0;
            if (fire) m_period = val + 1;
            else if (m_q.size() != 0) m_period = m_q.pop_front() + 1;
            m_q.delete();
        end else begin
            m_elapsed = wrap ? 0 : m_elapsed + 1;
            if (wrap && m_q.size() != 0) m_period = m_q.pop_front() + 1;
            if (fire) m_q.push_back(val);
        end
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        num_checks++;
        if (observed !== expected) begin
            num_errors++;
            $display("[TB] FAIL %s: observed %0h expected %0h", tag, observed, expected);
        end
    endtask

    task automatic checkAll();
        checkOutput("tick",       32'(tick),       32'(m_tick));
        checkOutput("done",       32'(done),       32'(m_done));
        checkOutput("clk_out",    32'(clk_out),    32'(m_clk));
        checkOutput("busy",       32'(busy),       32'(m_mode != 0));
        checkOutput("cfg_ready",  32'(cfg_bus.cfg_ready), 32'(m_q.size() == 0));
        checkOutput("tick_count", 32'(tick_count), m_tcount);
    endtask

    // Drive inputs (called at a falling edge), clock once, then check.
    task automatic applyStimulus(input logic st, input logic sp, input logic os,
                                 input logic v, input logic [31:0] d);
        start             = st;
        stop              = sp;
        oneshot           = os;
        cfg_bus.cfg_valid = v;
        cfg_bus.cfg_div   = d;
        @(posedge clk_in);
        modelEdge();
        @(negedge clk_in);
        checkAll();
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 32'd0);
    endtask

    // Asynchronous reset between clock edges; outputs must drop at once.
    task automatic doReset();
        reset = 1'b0;
        #1;
        modelReset();
        checkAll();
        @(negedge clk_in);
        reset = 1'b1;
    endtask

    initial begin
        cfg_bus.cfg_valid = 1'b0;
        cfg_bus.cfg_div   = '0;
        modelReset();
        #2;
        checkAll();
        @(negedge clk_in);
        @(negedge clk_in);
        reset = 1'b1;
        idleCycles(2);

        $display("[TB] continuous run at reset ratio");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        idleCycles(16);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);
        idleCycles(3);

        $display("[TB] idle reconfiguration");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        idleCycles(10);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

        $display("[TB] update deferred to period boundary");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd9);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        idleCycles(4);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd3);
        idleCycles(25);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

        $display("[TB] one-shot");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd5);
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 32'd0);
        idleCycles(12);

        $display("[TB] start with stop, and reset mid-run");
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        idleCycles(3);
        applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 32'd0);
        idleCycles(2);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 32'd7);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd2);
        idleCycles(3);
        doReset();
        idleCycles(3);

        $display("[TB] zero ratio clamp and tick_count wrap");
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 32'd0);
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0, 32'd0);
        idleCycles(600);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 32'd0);

        $display("[TB] randomized stimulus");
        for (int i = 0; i < 3000; i++) begin
            if ($urandom_range(0, 399) == 0) begin
                doReset();
            end else begin
                applyStimulus(logic'($urandom_range(0, 99) < 30),
                              logic'($urandom_range(0, 99) < 3),
                              logic'($urandom_range(0, 99) < 40),
                              logic'($urandom_range(0, 99) < 20),
                              32'($urandom_range(0, 7)));
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", num_checks, num_errors);
        $finish;
    end

endmodule
